fp_result_sink: RTL and testbench

//  Downstream consumer of the FP adder's AXI-Stream result channel. It buffers results
//  in a DEPTH-entry first-word-fall-through FIFO and re-presents them on a master
//  AXI-Stream port. It tracks occupancy, and optionally counts IEEE-754 special-class

---
 rtl/fp_result_pkg.sv | 22 ++
 rtl/fp_result_sink_if.sv | 12 +
 rtl/fp_class_decode.sv | 24 ++
 rtl/fp_result_sink.sv | 117 +++++++++++
 tb/tb_fp_result_sink.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_result_pkg.sv
// Shared types and constants for the FP adder result sink.
// fp32_t is the IEEE-754 single-precision field split; fp_class_e is the
// special-value class used by the optional result counters.
package fp_result_pkg;

  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  localparam int         FP32_W     = 32;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    FPC_NORM,
    FPC_ZERO,
    FPC_INF,
    FPC_NAN
  } fp_class_e;

endpackage

// File: rtl/fp_result_sink_if.sv
// AXI-Stream style channel (tvalid/tready/tdata) used for both the result
// input and the buffered output of fp_result_sink.
interface fp_result_sink_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fp_class_decode.sv
// Combinational IEEE-754 single-precision class decode. Sign is ignored:
// +/-0, +/-Inf and any NaN map to one class each; denormals and normals
// both report FPC_NORM.
module fp_class_decode
  import fp_result_pkg::*;
(
  input  fp32_t     i_data,
  output fp_class_e o_class
);

  logic unused_sign;
  assign unused_sign = i_data.sign;

  // Exponent all-ones splits into NaN/Inf on the mantissa; all-zero word is zero
  always_comb begin
    o_class = FPC_NORM;
    if (i_data.exp == FP_EXP_MAX) begin
      o_class = (i_data.mant != '0) ? FPC_NAN : FPC_INF;
    end else if ((i_data.exp == '0) && (i_data.mant == '0)) begin
      o_class = FPC_ZERO;
    end
  end

endmodule

// File: rtl/fp_result_sink.sv
// FP adder result sink: DEPTH-entry first-word-fall-through FIFO between the
// adder result stream and a downstream AXI-Stream master port.
// Optional feature macro FP_RESULT_CLASS_EN: when defined, every accepted
// result is classified and saturating NaN/Inf/zero counters are kept; when
// undefined the counter ports are tied to zero and no classify logic exists.
module fp_result_sink
  import fp_result_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  fp_result_sink_if.slave          s_axis_result,
  fp_result_sink_if.master         m_axis,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [CNT_W-1:0]         o_nan_cnt,
  output logic [CNT_W-1:0]         o_inf_cnt,
  output logic [CNT_W-1:0]         o_zero_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     count_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Ready and valid come from pointer state only, so there is no
  // combinational path from the input valid to either handshake output
  assign s_axis_result.tready = !full;
  assign m_axis.tvalid        = !empty;
  assign m_axis.tdata         = mem[rd_ptr[AW-1:0]];

  assign push = s_axis_result.tvalid & s_axis_result.tready;
  assign pop  = m_axis.tvalid & m_axis.tready;

  assign o_count = count_q;

  // Pointer and occupancy update; count tracks wr_ptr - rd_ptr as a register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head word reads zero with nothing held
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= s_axis_result.tdata;
    end
  end

`ifdef FP_RESULT_CLASS_EN
  fp_class_e        cls;
  logic [CNT_W-1:0] nan_cnt;
  logic [CNT_W-1:0] inf_cnt;
  logic [CNT_W-1:0] zero_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  fp_class_decode u_class_decode (
    .i_data  (fp32_t'(s_axis_result.tdata)),
    .o_class (cls)
  );

  // Count special-class results as they are accepted, holding at all-ones
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      nan_cnt  <= '0;
      inf_cnt  <= '0;
      zero_cnt <= '0;
    end else if (push) begin
      case (cls)
        FPC_NAN:  nan_cnt  <= sat_inc(nan_cnt);
        FPC_INF:  inf_cnt  <= sat_inc(inf_cnt);
        FPC_ZERO: zero_cnt <= sat_inc(zero_cnt);
        default:  ;
      endcase
    end
  end

  assign o_nan_cnt  = nan_cnt;
  assign o_inf_cnt  = inf_cnt;
  assign o_zero_cnt = zero_cnt;
`else
  assign o_nan_cnt  = '0;
  assign o_inf_cnt  = '0;
  assign o_zero_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_result_sink.sv
// Directed testbench for fp_result_sink. Counter expectations follow the
// FP_RESULT_CLASS_EN macro of the build.
module tb_fp_result_sink;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic [CNT_W-1:0] nan_cnt;
  logic [CNT_W-1:0] inf_cnt;
  logic [CNT_W-1:0] zero_cnt;

  int checks;
  int failures;

  fp_result_sink_if #(.DATA_W(DATA_W)) s_if ();
  fp_result_sink_if #(.DATA_W(DATA_W)) m_if ();

  fp_result_sink #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .s_axis_result (s_if),
    .m_axis        (m_if),
    .o_count       (count),
    .o_nan_cnt     (nan_cnt),
    .o_inf_cnt     (inf_cnt),
    .o_zero_cnt    (zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output must hold while stalled: checked at every falling edge
  logic        stall_prev;
  logic [31:0] stall_data;
  initial begin
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (m_if.tvalid !== 1'b1 || m_if.tdata !== stall_data) begin
            failures++;
            $display("FAIL stall_hold: tvalid=%b tdata=%h required tvalid=1 tdata=%h",
                     m_if.tvalid, m_if.tdata, stall_data);
          end
        end
        stall_prev = m_if.tvalid && !m_if.tready;
        stall_data = m_if.tdata;
      end
    end
  end

  task automatic do_reset();
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1 || m_if.tdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: count=%0d tvalid=%b tready=%b tdata=%h required 0 0 1 00000000",
               count, m_if.tvalid, s_if.tready, m_if.tdata);
    end
    checks++;
    if (nan_cnt !== '0 || inf_cnt !== '0 || zero_cnt !== '0) begin
      failures++;
      $display("FAIL reset_counters: nan=%h inf=%h zero=%h required 0 0 0", nan_cnt, inf_cnt, zero_cnt);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h3F800000;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_no_bypass: tvalid=%b required 0", m_if.tvalid);
    end
    tick();
    s_if.tvalid = 1'b0;
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h3F800000 || count !== 4'd1) begin
      failures++;
      $display("FAIL single_push: tvalid=%b tdata=%h count=%0d required 1 3f800000 1",
               m_if.tvalid, m_if.tdata, count);
    end
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
    checks++;
    if (m_if.tvalid !== 1'b0 || count !== 4'd0) begin
      failures++;
      $display("FAIL single_drain: tvalid=%b count=%0d required 0 0", m_if.tvalid, count);
    end
  endtask

  task automatic test_full();
    m_if.tready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'(i);
      tick();
    end
    checks++;
    if (s_if.tready !== 1'b0 || count !== 4'd8) begin
      failures++;
      $display("FAIL full_state: tready=%b count=%0d required 0 8", s_if.tready, count);
    end
    s_if.tdata = 32'd9;
    tick();
    checks++;
    if (count !== 4'd8 || m_if.tdata !== 32'd1) begin
      failures++;
      $display("FAIL full_ninth_beat: count=%0d head=%h required 8 00000001", count, m_if.tdata);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'(i)) begin
        failures++;
        $display("FAIL full_order: beat=%0d tvalid=%b tdata=%h required 1 %h", i, m_if.tvalid, m_if.tdata, 32'(i));
      end
      tick();
      if (i == 1) begin
        checks++;
        if (s_if.tready !== 1'b1 || count !== 4'd7) begin
          failures++;
          $display("FAIL full_tready_rise: tready=%b count=%0d required 1 7", s_if.tready, count);
        end
      end
    end
    m_if.tready = 1'b0;
    checks++;
    if (m_if.tvalid !== 1'b0 || count !== 4'd0) begin
      failures++;
      $display("FAIL full_drained: tvalid=%b count=%0d required 0 0", m_if.tvalid, count);
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'(10 + i);
      tick();
    end
    m_if.tready = 1'b1;
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'(13 + k);
      #1;
      if (m_if.tdata !== 32'(10 + k) || count !== 4'd3 || m_if.tvalid !== 1'b1) errs++;
      if (k == 0 || k == 19) begin
        checks++;
        if (m_if.tdata !== 32'(10 + k) || count !== 4'd3) begin
          failures++;
          $display("FAIL b2b_cycle%0d: tdata=%h count=%0d required %h 3", k, m_if.tdata, count, 32'(10 + k));
        end
      end
      tick();
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL b2b_stream: bad_cycles=%0d required 0", errs);
    end
    s_if.tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (m_if.tdata !== 32'(30 + i) || count !== 4'(3 - i)) begin
        failures++;
        $display("FAIL b2b_drain%0d: tdata=%h count=%0d required %h %0d", i, m_if.tdata, count, 32'(30 + i), 3 - i);
      end
      tick();
    end
    m_if.tready = 1'b0;
    checks++;
    if (m_if.tvalid !== 1'b0 || count !== 4'd0) begin
      failures++;
      $display("FAIL b2b_empty: tvalid=%b count=%0d required 0 0", m_if.tvalid, count);
    end
  endtask

  task automatic test_class();
    logic [31:0] vec [5];
    logic [CNT_W-1:0] exp_one;
    vec[0] = 32'h7FC00000;
    vec[1] = 32'hFF800000;
    vec[2] = 32'h80000000;
    vec[3] = 32'h00000001;
    vec[4] = 32'h3F800000;
`ifdef FP_RESULT_CLASS_EN
    exp_one = 16'd1;
`else
    exp_one = 16'd0;
`endif
    do_reset();
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = vec[i];
      tick();
    end
    s_if.tvalid = 1'b0;
    checks++;
    if (nan_cnt !== exp_one || inf_cnt !== exp_one || zero_cnt !== exp_one) begin
      failures++;
      $display("FAIL class_counts: nan=%h inf=%h zero=%h required %h each", nan_cnt, inf_cnt, zero_cnt, exp_one);
    end
    m_if.tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (m_if.tdata !== vec[i]) begin
        failures++;
        $display("FAIL class_data%0d: tdata=%h required %h", i, m_if.tdata, vec[i]);
      end
      tick();
    end
    m_if.tready = 1'b0;
  endtask

  task automatic test_async_reset();
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'hA0 + 32'(i);
      tick();
    end
    s_if.tvalid = 1'b0;
    checks++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL areset_pre: count=%0d required 5", count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1 || m_if.tdata !== 32'h0) begin
      failures++;
      $display("FAIL areset_immediate: count=%0d tvalid=%b tready=%b tdata=%h required 0 0 1 00000000",
               count, m_if.tvalid, s_if.tready, m_if.tdata);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (count !== 4'd0 || m_if.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL areset_release: count=%0d tvalid=%b required 0 0", count, m_if.tvalid);
    end
  endtask

  task automatic test_saturate();
    do_reset();
`ifdef FP_RESULT_CLASS_EN
    force dut.zero_cnt = 16'hFFFF;
    #1;
    release dut.zero_cnt;
    #1;
`endif
    m_if.tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'h00000000;
      tick();
    end
    s_if.tvalid = 1'b0;
    checks++;
`ifdef FP_RESULT_CLASS_EN
    if (zero_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL zero_saturate: zero=%h required ffff", zero_cnt);
    end
`else
    if (zero_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL zero_tied_off: zero=%h required 0000", zero_cnt);
    end
`endif
    checks++;
    if (count !== 4'd2 || m_if.tdata !== 32'h0) begin
      failures++;
      $display("FAIL saturate_fifo: count=%0d tdata=%h required 2 00000000", count, m_if.tdata);
    end
    m_if.tready = 1'b1;
    tick();
    tick();
    m_if.tready = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_class();
    test_async_reset();
    test_saturate();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
